// File: rtl/mipi_rx_packet_parser.sv
// DSI per-lane packet parser: splits an aligned HS burst into packets,
// decodes and ECC-checks each header, forwards long-packet payload and
// checks the trailing CRC-16. All outputs are registered.
module mipi_rx_packet_parser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        hdr_valid,
    output logic [1:0]  hdr_vc,
    output logic [5:0]  hdr_dt,
    output logic [15:0] hdr_wc,
    output logic        hdr_long,
    output logic        hdr_ecc_err,
    output logic [7:0]  pld_data,
    output logic        pld_valid,
    output logic        pld_last,
    output logic        pkt_done,
    output logic        crc_err
);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, DROP} state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    // Bit masks over {byte2, byte1, DI} selecting the data bits of each
    // Hamming parity bit P0..P5.
    localparam logic [23:0] ECC_MASK [6] = '{
        24'hF12CB7, 24'hF2555B, 24'h749A6D,
        24'hB8E38E, 24'hDF03F0, 24'hEFFC00
    };

    state_t      state_reg, state_next;
    logic [1:0]  idx_reg, idx_next;
    logic [7:0]  di_reg, di_next;
    logic [7:0]  b1_reg, b1_next;
    logic [7:0]  b2_reg, b2_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [15:0] crc_reg, crc_next;
    logic [7:0]  crc_lo_reg, crc_lo_next;

    logic        hdr_valid_next, hdr_long_next, hdr_ecc_err_next;
    logic [1:0]  hdr_vc_next;
    logic [5:0]  hdr_dt_next;
    logic [15:0] hdr_wc_next;
    logic [7:0]  pld_data_next;
    logic        pld_valid_next, pld_last_next, pkt_done_next, crc_err_next;

    logic [23:0] hdr_bits;
    logic [5:0]  ecc_calc;
    logic        ecc_bad;
    logic        pkt_is_long;

    // One reflected CRC-16 (poly 0x8408) step over a byte, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // Long packets are the data types whose low nibble is 9, C, D or E.
    function automatic logic is_long(input logic [5:0] dt);
        return (dt[3:0] == 4'h9) || (dt[3:0] == 4'hC) ||
               (dt[3:0] == 4'hD) || (dt[3:0] == 4'hE);
    endfunction

    assign hdr_bits    = {b2_reg, b1_reg, di_reg};
    assign pkt_is_long = is_long(di_reg[5:0]);
    // The top two ECC bits must be zero, so compare the whole byte.
    assign ecc_bad     = (din != {2'b00, ecc_calc});

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_ecc
            assign ecc_calc[gi] = ^(hdr_bits & ECC_MASK[gi]);
        end
    endgenerate

    // Next-state and next-output logic for the packet walker.
    always_comb begin
        state_next       = state_reg;
        idx_next         = idx_reg;
        di_next          = di_reg;
        b1_next          = b1_reg;
        b2_next          = b2_reg;
        cnt_next         = cnt_reg;
        crc_next         = crc_reg;
        crc_lo_next      = crc_lo_reg;
        hdr_valid_next   = 1'b0;
        hdr_vc_next      = hdr_vc;
        hdr_dt_next      = hdr_dt;
        hdr_wc_next      = hdr_wc;
        hdr_long_next    = hdr_long;
        hdr_ecc_err_next = hdr_ecc_err;
        pld_data_next    = pld_data;
        pld_valid_next   = 1'b0;
        pld_last_next    = 1'b0;
        pkt_done_next    = 1'b0;
        crc_err_next     = crc_err;

        if (!din_valid) begin
            // End of burst (or truncation): abandon whatever was in flight.
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_next   = 2'd0;
                    state_next = (din == SYNC_BYTE) ? HDR : DROP;
                end
                HDR: begin
                    idx_next = idx_reg + 2'd1;
                    case (idx_reg)
                        2'd0: di_next = din;
                        2'd1: b1_next = din;
                        2'd2: b2_next = din;
                        default: begin
                            hdr_valid_next   = 1'b1;
                            hdr_vc_next      = di_reg[7:6];
                            hdr_dt_next      = di_reg[5:0];
                            hdr_wc_next      = {b2_reg, b1_reg};
                            hdr_long_next    = pkt_is_long;
                            hdr_ecc_err_next = ecc_bad;
                            cnt_next         = {b2_reg, b1_reg};
                            crc_next         = 16'hFFFF;
                            idx_next         = 2'd0;
                            if (ecc_bad)
                                state_next = DROP;
                            else if (!pkt_is_long)
                                state_next = HDR;
                            else if ({b2_reg, b1_reg} != 16'd0)
                                state_next = PAYLOAD;
                            else
                                state_next = CRC;
                        end
                    endcase
                end
                PAYLOAD: begin
                    pld_data_next  = din;
                    pld_valid_next = 1'b1;
                    cnt_next       = cnt_reg - 16'd1;
                    crc_next       = crc16_byte(crc_reg, din);
                    if (cnt_reg == 16'd1) begin
                        pld_last_next = 1'b1;
                        idx_next      = 2'd0;
                        state_next    = CRC;
                    end
                end
                CRC: begin
                    if (idx_reg == 2'd0) begin
                        crc_lo_next = din;
                        idx_next    = 2'd1;
                    end else begin
                        pkt_done_next = 1'b1;
                        crc_err_next  = ({din, crc_lo_reg} != crc_reg);
                        idx_next      = 2'd0;
                        state_next    = HDR;
                    end
                end
                DROP: state_next = DROP;
                default: state_next = IDLE;
            endcase
        end
    end

    // State and registered outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= 2'd0;
            di_reg      <= 8'd0;
            b1_reg      <= 8'd0;
            b2_reg      <= 8'd0;
            cnt_reg     <= 16'd0;
            crc_reg     <= 16'd0;
            crc_lo_reg  <= 8'd0;
            hdr_valid   <= 1'b0;
            hdr_vc      <= 2'd0;
            hdr_dt      <= 6'd0;
            hdr_wc      <= 16'd0;
            hdr_long    <= 1'b0;
            hdr_ecc_err <= 1'b0;
            pld_data    <= 8'd0;
            pld_valid   <= 1'b0;
            pld_last    <= 1'b0;
            pkt_done    <= 1'b0;
            crc_err     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            di_reg      <= di_next;
            b1_reg      <= b1_next;
            b2_reg      <= b2_next;
            cnt_reg     <= cnt_next;
            crc_reg     <= crc_next;
            crc_lo_reg  <= crc_lo_next;
            hdr_valid   <= hdr_valid_next;
            hdr_vc      <= hdr_vc_next;
            hdr_dt      <= hdr_dt_next;
            hdr_wc      <= hdr_wc_next;
            hdr_long    <= hdr_long_next;
            hdr_ecc_err <= hdr_ecc_err_next;
            pld_data    <= pld_data_next;
            pld_valid   <= pld_valid_next;
            pld_last    <= pld_last_next;
            pkt_done    <= pkt_done_next;
            crc_err     <= crc_err_next;
        end
    end

endmodule

// File: tb/tb_mipi_rx_packet_parser.sv
// Scoreboard bench for mipi_rx_packet_parser: bursts are built as byte
// lists, a byte-list walker predicts every output event with its cycle,
// and a monitor pops and compares whenever the parser emits something.
module tb_mipi_rx_packet_parser;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        din_valid;
    logic        hdr_valid;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic        hdr_long;
    logic        hdr_ecc_err;
    logic [7:0]  pld_data;
    logic        pld_valid;
    logic        pld_last;
    logic        pkt_done;
    logic        crc_err;

    mipi_rx_packet_parser dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .hdr_valid(hdr_valid), .hdr_vc(hdr_vc), .hdr_dt(hdr_dt), .hdr_wc(hdr_wc),
        .hdr_long(hdr_long), .hdr_ecc_err(hdr_ecc_err),
        .pld_data(pld_data), .pld_valid(pld_valid), .pld_last(pld_last),
        .pkt_done(pkt_done), .crc_err(crc_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; logic lng; logic err; int cyc; } hdr_exp_t;
    typedef struct { logic [7:0] d; logic last; int cyc; } pld_exp_t;
    typedef struct { logic err; int cyc; } done_exp_t;

    hdr_exp_t  hdr_q[$];
    pld_exp_t  pld_q[$];
    done_exp_t done_q[$];

    logic [7:0] burst[$];
    logic [7:0] pl_q[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input bit ok, input string act, input string exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, exp);
        end else begin
            $display("pass %s: %s", name, act);
        end
    endtask

    // DSI Hamming ECC: each data bit contributes its own 6-bit column.
    function automatic logic [5:0] ref_ecc(input logic [23:0] d);
        logic [5:0] col [24];
        logic [5:0] e;
        col = '{6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
                6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
                6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};
        e = 6'd0;
        for (int i = 0; i < 24; i++) if (d[i]) e ^= col[i];
        return e;
    endfunction

    // Reflected CRC-16/CCITT, one byte, LSB first.
    function automatic logic [15:0] ref_crc(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        return c;
    endfunction

    function automatic bit ref_long(input logic [5:0] dt);
        return dt[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
    endfunction

    task automatic add_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc_flip);
        burst.push_back(di);
        burst.push_back(wc[7:0]);
        burst.push_back(wc[15:8]);
        burst.push_back({2'b00, ref_ecc({wc, di})} ^ ecc_flip);
    endtask

    // Appends pl_q plus its CRC; flip0 corrupts the first byte after the CRC is taken.
    task automatic add_payload(input logic [7:0] flip0);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (pl_q[i]) c = ref_crc(c, pl_q[i]);
        foreach (pl_q[i]) burst.push_back((i == 0) ? (pl_q[i] ^ flip0) : pl_q[i]);
        burst.push_back(c[7:0]);
        burst.push_back(c[15:8]);
    endtask

    // Walk the burst byte list and predict every output event. Byte i is
    // sampled on the edge that makes cyc = base+i+1.
    task automatic model_burst(input int base);
        int n, p;
        logic [15:0] wc, c, rx;
        logic [7:0] di;
        logic err;
        n = burst.size();
        if (n == 0 || burst[0] != 8'hB8) return;
        p = 1;
        forever begin
            if (p + 4 > n) return;
            di  = burst[p];
            wc  = {burst[p+2], burst[p+1]};
            err = (burst[p+3] != {2'b00, ref_ecc({wc, di})});
            hdr_q.push_back('{vc: di[7:6], dt: di[5:0], wc: wc, lng: ref_long(di[5:0]),
                              err: err, cyc: base + p + 4});
            p += 4;
            if (err) return;
            if (ref_long(di[5:0])) begin
                c = 16'hFFFF;
                for (int k = 0; k < int'(wc); k++) begin
                    if (p >= n) return;
                    pld_q.push_back('{d: burst[p], last: (k == int'(wc) - 1), cyc: base + p + 1});
                    c = ref_crc(c, burst[p]);
                    p++;
                end
                if (p + 2 > n) return;
                rx = {burst[p+1], burst[p]};
                done_q.push_back('{err: (rx != c), cyc: base + p + 2});
                p += 2;
            end
        end
    endtask

    task automatic send_burst();
        int base;
        @(posedge clk); #1;
        base = cyc;
        model_burst(base);
        foreach (burst[i]) begin
            din = burst[i];
            din_valid = 1'b1;
            @(posedge clk); #1;
        end
        din_valid = 1'b0;
        din = 8'($urandom);
        repeat (2) @(posedge clk);
        burst.delete();
    endtask

    task automatic check_zero(input string name);
        logic [38:0] v;
        v = {hdr_valid, hdr_vc, hdr_dt, hdr_wc, hdr_long, hdr_ecc_err,
             pld_data, pld_valid, pld_last, pkt_done, crc_err};
        check(name, v === 39'd0, $sformatf("outputs=%h", v), "all zero");
    endtask

    // Monitor: pop and compare each event the parser presents.
    initial begin
        hdr_exp_t  he;
        pld_exp_t  pe;
        done_exp_t de;
        forever begin
            @(negedge clk);
            if (hdr_valid === 1'b1) begin
                if (hdr_q.size() == 0) begin
                    check("hdr_unexpected", 1'b0, $sformatf("hdr dt=%h cyc=%0d", hdr_dt, cyc), "no header");
                end else begin
                    he = hdr_q.pop_front();
                    check("hdr", {hdr_vc, hdr_dt, hdr_wc, hdr_long, hdr_ecc_err} ==
                                 {he.vc, he.dt, he.wc, he.lng, he.err} && cyc == he.cyc,
                          $sformatf("vc=%0d dt=%h wc=%h long=%b eccerr=%b cyc=%0d",
                                    hdr_vc, hdr_dt, hdr_wc, hdr_long, hdr_ecc_err, cyc),
                          $sformatf("vc=%0d dt=%h wc=%h long=%b eccerr=%b cyc=%0d",
                                    he.vc, he.dt, he.wc, he.lng, he.err, he.cyc));
                end
            end
            if (pld_valid === 1'b1) begin
                if (pld_q.size() == 0) begin
                    check("pld_unexpected", 1'b0, $sformatf("pld %h cyc=%0d", pld_data, cyc), "no payload");
                end else begin
                    pe = pld_q.pop_front();
                    check("pld", pld_data == pe.d && pld_last == pe.last && cyc == pe.cyc,
                          $sformatf("data=%h last=%b cyc=%0d", pld_data, pld_last, cyc),
                          $sformatf("data=%h last=%b cyc=%0d", pe.d, pe.last, pe.cyc));
                end
            end
            if (pkt_done === 1'b1) begin
                if (done_q.size() == 0) begin
                    check("done_unexpected", 1'b0, $sformatf("pkt_done cyc=%0d", cyc), "no pkt_done");
                end else begin
                    de = done_q.pop_front();
                    check("pkt_done", crc_err == de.err && cyc == de.cyc,
                          $sformatf("crc_err=%b cyc=%0d", crc_err, cyc),
                          $sformatf("crc_err=%b cyc=%0d", de.err, de.cyc));
                end
            end
        end
    end

    // Stimulus.
    initial begin
        logic [7:0]  di, ef, fl;
        logic [15:0] wc;
        int npk, cut;

        rst_n = 1'b0; din_valid = 1'b0; din = 8'h00;
        repeat (3) @(posedge clk);
        #1 din_valid = 1'b1; din = 8'hB8;      // reset must win over activity
        @(posedge clk); @(negedge clk);
        check_zero("reset_state");
        din_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Short packet with the literal header bytes.
        burst = '{8'hB8, 8'h05, 8'h11, 8'h00, 8'h36};
        send_burst();
        // Bad ECC, then a long packet that must be dropped.
        burst = '{8'hB8, 8'h05, 8'h11, 8'h00, 8'h37};
        pl_q = '{8'h2C, 8'hAA, 8'h55};
        add_hdr(8'h39, 16'd3, 8'h00); add_payload(8'h00);
        send_burst();
        // Long packet, good CRC, then same with one payload bit flipped.
        burst = '{8'hB8};
        add_hdr(8'h39, 16'd3, 8'h00); add_payload(8'h00);
        send_burst();
        burst = '{8'hB8};
        add_hdr(8'h39, 16'd3, 8'h00); add_payload(8'h04);
        send_burst();
        // Zero-length long packet: CRC bytes are the seed, FF FF.
        burst = '{8'hB8};
        pl_q.delete();
        add_hdr(8'h09, 16'd0, 8'h00); add_payload(8'h00);
        send_burst();
        // Back-to-back short + long WC=2, then EoT junk.
        burst = '{8'hB8};
        add_hdr(8'h41, 16'h1234, 8'h00);
        pl_q = '{8'h5A, 8'hC3};
        add_hdr(8'h6C, 16'd2, 8'h00); add_payload(8'h00);
        repeat (4) burst.push_back(8'hFF);
        send_burst();
        // Truncation after the first payload byte.
        burst = '{8'hB8};
        add_hdr(8'h29, 16'd3, 8'h00);
        burst.push_back(8'h77);
        send_burst();
        // Burst not starting with sync.
        burst = '{8'h12, 8'hB8, 8'h05, 8'h11, 8'h00, 8'h36};
        send_burst();

        // Randomized bursts.
        for (int b = 0; b < 40; b++) begin
            burst.delete();
            burst.push_back(($urandom_range(0, 19) == 0) ? 8'h5A : 8'hB8);
            npk = $urandom_range(1, 4);
            for (int k = 0; k < npk; k++) begin
                di = 8'($urandom);
                ef = ($urandom_range(0, 9) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                if (ref_long(di[5:0])) begin
                    wc = 16'($urandom_range(0, 12));
                    pl_q.delete();
                    for (int j = 0; j < int'(wc); j++) pl_q.push_back(8'($urandom));
                    fl = ($urandom_range(0, 6) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
                    add_hdr(di, wc, ef);
                    add_payload(fl);
                end else begin
                    wc = 16'($urandom);
                    add_hdr(di, wc, ef);
                end
            end
            if ($urandom_range(0, 1) == 1) repeat (4) burst.push_back(8'hFF);
            if ($urandom_range(0, 4) == 0) begin
                cut = $urandom_range(1, burst.size() - 1);
                while (burst.size() > cut) void'(burst.pop_back());
            end
            send_burst();
        end

        // Reset asserted mid-payload while the burst continues.
        burst = '{8'hB8};
        add_hdr(8'h39, 16'd3, 8'h00);
        burst.push_back(8'h11);
        @(posedge clk); #1;
        model_burst(cyc);
        foreach (burst[i]) begin
            din = burst[i]; din_valid = 1'b1;
            @(posedge clk); #1;
        end
        din = 8'h22; rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        check_zero("reset_mid_payload");
        din = 8'hB8;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_hold_active");
        @(posedge clk); #1 rst_n = 1'b1; din = 8'h00;
        repeat (3) @(posedge clk);
        #1 din_valid = 1'b0;
        repeat (2) @(posedge clk);
        burst.delete();
        burst = '{8'hB8};
        pl_q = '{8'hDE, 8'hAD};
        add_hdr(8'h8E, 16'd2, 8'h00); add_payload(8'h00);
        send_burst();

        repeat (10) @(posedge clk);
        check("hdr_drained", hdr_q.size() == 0, $sformatf("%0d left", hdr_q.size()), "0 left");
        check("pld_drained", pld_q.size() == 0, $sformatf("%0d left", pld_q.size()), "0 left");
        check("done_drained", done_q.size() == 0, $sformatf("%0d left", done_q.size()), "0 left");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
